// File: rtl/term_gather.sv
// term_gather: collects serial terms into a zero-padded vector for an adder tree
module term_gather #(
  parameter int NUM_ELEMENTS = 4,
  parameter int BIT_LEN = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [BIT_LEN-1:0]           i_dat,
  input  logic                         i_val,
  input  logic                         i_eop,
  output logic                         o_rdy,
  output logic [BIT_LEN-1:0]           o_terms [NUM_ELEMENTS],
  output logic [$clog2(NUM_ELEMENTS+1)-1:0] o_cnt,
  output logic                         o_val,
  input  logic                         i_rdy
);
  localparam int CW = $clog2(NUM_ELEMENTS + 1);
  localparam int IW = $clog2(NUM_ELEMENTS);
  localparam logic [IW-1:0] LAST = IW'(NUM_ELEMENTS - 1);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state;
  logic [IW-1:0] idx;
  assign o_rdy = state == COLLECT && !i_rst;
  // Terms are cleared on every frame start, so unfilled slots of a short frame read zero
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == HOLD && i_rdy)) begin
      state <= COLLECT;
      idx <= '0;
      o_cnt <= '0;
      o_val <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++) o_terms[i] <= '0;
    end else if (state == COLLECT && i_val) begin
      o_terms[idx] <= i_dat;
      if (i_eop || idx == LAST) begin
        state <= HOLD;
        o_val <= 1'b1;
        o_cnt <= CW'(idx) + CW'(1);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule
